// File: rtl/accumulator_datapath.sv
// Accumulator datapath: register A, operand select, 8-op ALU and an
// iterative shift-add multiplier sequenced by a two-state FSM.
module accumulator_datapath #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         op_valid,
  input  logic [2:0]   op,
  input  logic [1:0]   src,
  input  logic [N-1:0] ir_in,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] acc_out,
  output logic         busy,
  output logic         done,
  output logic         zero,
  output logic         pos,
  output logic         carry,
  output logic         ovf
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t         state, state_n;
  logic [N-1:0]   acc, acc_n;
  logic           carry_r, carry_n;
  logic           ovf_r, ovf_n;
  logic           busy_r, busy_n;
  logic           done_r, done_n;
  logic [CW-1:0]  count, count_n;

  // Multiplier working registers: multiplicand shifts left, multiplier
  // shifts right, so each step only looks at bit 0 of the multiplier.
  logic [2*N-1:0] mcand, mcand_n;
  logic [N-1:0]   mplier, mplier_n;
  logic [2*N-1:0] prod, prod_n;
  logic [2*N-1:0] step;

  logic [N-1:0]   operand;
  logic [N:0]     sum;
  logic [N:0]     diff;

  assign operand = (src == 2'b00) ? ir_in :
                   (src == 2'b01) ? data_in : '0;

  // Extra top bit captures carry-out for ADD and borrow for SUB.
  assign sum  = {1'b0, acc} + {1'b0, operand};
  assign diff = {1'b0, acc} - {1'b0, operand};
  assign step = prod + (mplier[0] ? mcand : '0);

  // Next-state, ALU and multiply-step logic.
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    carry_n  = carry_r;
    ovf_n    = ovf_r;
    busy_n   = busy_r;
    done_n   = 1'b0;
    count_n  = count;
    mcand_n  = mcand;
    mplier_n = mplier;
    prod_n   = prod;
    case (state)
      ST_IDLE: begin
        if (op_valid) begin
          if (op == OP_MUL) begin
            mcand_n  = {{N{1'b0}}, acc};
            mplier_n = operand;
            prod_n   = '0;
            count_n  = '0;
            busy_n   = 1'b1;
            state_n  = ST_MUL;
          end else begin
            done_n = 1'b1;
            case (op)
              OP_LOAD: acc_n = operand;
              OP_ADD: begin
                acc_n   = sum[N-1:0];
                carry_n = sum[N];
                ovf_n   = (acc[N-1] == operand[N-1]) && (sum[N-1] != acc[N-1]);
              end
              OP_SUB: begin
                acc_n   = diff[N-1:0];
                carry_n = ~diff[N];
                ovf_n   = (acc[N-1] != operand[N-1]) && (diff[N-1] != acc[N-1]);
              end
              OP_AND: acc_n = acc & operand;
              OP_OR:  acc_n = acc | operand;
              OP_SHL: begin
                acc_n   = {acc[N-2:0], 1'b0};
                carry_n = acc[N-1];
                ovf_n   = acc[N-1] ^ acc[N-2];
              end
              OP_SHR: begin
                acc_n   = {1'b0, acc[N-1:1]};
                carry_n = acc[0];
                ovf_n   = 1'b0;
              end
              default: acc_n = acc;
            endcase
          end
        end
      end
      ST_MUL: begin
        prod_n   = step;
        mcand_n  = {mcand[2*N-2:0], 1'b0};
        mplier_n = {1'b0, mplier[N-1:1]};
        count_n  = count + CW'(1);
        if (count == LAST) begin
          acc_n   = step[N-1:0];
          carry_n = |step[2*N-1:N];
          ovf_n   = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          count_n = '0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Architectural state and control; clear aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (clear) begin
      state   <= ST_IDLE;
      acc     <= '0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      count   <= '0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      carry_r <= carry_n;
      ovf_r   <= ovf_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
      count   <= count_n;
    end
  end

  // Multiplier working registers; only meaningful while in ST_MUL.
  always_ff @(posedge clk) begin
    mcand  <= mcand_n;
    mplier <= mplier_n;
    prod   <= prod_n;
  end

  assign acc_out = acc;
  assign busy    = busy_r;
  assign done    = done_r;
  assign carry   = carry_r;
  assign ovf     = ovf_r;
  assign zero    = (acc == '0);
  assign pos     = ~acc[N-1];

endmodule

// File: tb/tb_accumulator_datapath.sv
// Directed bench for accumulator_datapath with hand-computed expectations.
module tb_accumulator_datapath;

  localparam logic [2:0] LOAD = 3'b000, ADD = 3'b001, SUB = 3'b010, AND_ = 3'b011,
                         OR_ = 3'b100, SHL = 3'b101, SHR = 3'b110, MUL = 3'b111;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       op_valid = 1'b0;
  logic [2:0] op = 3'b000;
  logic [1:0] src = 2'b00;
  logic [7:0] ir_in = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic [7:0] acc_out;
  logic       busy, done, zero, pos, carry, ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int edges, bcyc, pulses;

  accumulator_datapath #(.N(8)) dut (
    .clk(clk), .clear(clear), .op_valid(op_valid), .op(op), .src(src),
    .ir_in(ir_in), .data_in(data_in), .acc_out(acc_out), .busy(busy),
    .done(done), .zero(zero), .pos(pos), .carry(carry), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-edge issue; the unselected bus carries the complement to expose a bad mux.
  task automatic issue(input logic [2:0] o, input logic [1:0] s, input logic [7:0] v);
    op = o;
    src = s;
    if (s == 2'b01) begin
      data_in = v;
      ir_in = ~v;
    end else begin
      ir_in = v;
      data_in = ~v;
    end
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
  endtask

  // Waits (bounded) for done after a MUL acceptance; counts edges and busy cycles.
  // With inject set, pulses an ADD and scrambles the buses while busy.
  task automatic mul_wait(input bit inject, output int e, output int b);
    e = 1;
    b = 0;
    while (!done && e < 20) begin
      if (busy) b++;
      if (inject && b == 3) begin
        op = ADD;
        src = 2'b00;
        ir_in = 8'h01;
        data_in = 8'h33;
        op_valid = 1'b1;
      end else begin
        op_valid = 1'b0;
      end
      tick();
      e++;
    end
    op_valid = 1'b0;
  endtask

  initial begin
    // Reset
    tick();
    clear = 1'b0;
    chk("rst_acc", acc_out, 8'h00);
    chk("rst_zero", zero, 1'b1);
    chk("rst_pos", pos, 1'b1);
    chk("rst_carry", carry, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    // LOAD data_in 0x05, ADD ir 0xFB -> 0x00 with carry
    issue(LOAD, 2'b01, 8'h05);
    chk("ld5_acc", acc_out, 8'h05);
    chk("ld5_done", done, 1'b1);
    issue(ADD, 2'b00, 8'hFB);
    chk("add_acc", acc_out, 8'h00);
    chk("add_done", done, 1'b1);
    chk("add_zero", zero, 1'b1);
    chk("add_carry", carry, 1'b1);
    chk("add_ovf", ovf, 1'b0);
    tick();
    chk("idle_done", done, 1'b0);
    chk("idle_acc", acc_out, 8'h00);

    // Signed overflow on ADD
    issue(LOAD, 2'b00, 8'h7F);
    issue(ADD, 2'b00, 8'h01);
    chk("ovf_acc", acc_out, 8'h80);
    chk("ovf_ovf", ovf, 1'b1);
    chk("ovf_carry", carry, 1'b0);
    chk("ovf_pos", pos, 1'b0);
    chk("ovf_zero", zero, 1'b0);

    // SUB with borrow, then SHR
    issue(LOAD, 2'b00, 8'h03);
    issue(SUB, 2'b00, 8'h05);
    chk("sub_acc", acc_out, 8'hFE);
    chk("sub_carry", carry, 1'b0);
    chk("sub_ovf", ovf, 1'b0);
    chk("sub_pos", pos, 1'b0);
    issue(SHR, 2'b00, 8'hFF);
    chk("shr_acc", acc_out, 8'h7F);
    chk("shr_carry", carry, 1'b0);
    chk("shr_pos", pos, 1'b1);

    // SUB signed overflow, no borrow
    issue(LOAD, 2'b01, 8'h80);
    issue(SUB, 2'b01, 8'h01);
    chk("subv_acc", acc_out, 8'h7F);
    chk("subv_ovf", ovf, 1'b1);
    chk("subv_carry", carry, 1'b1);

    // SHL flags, then LOAD/AND/OR hold flags
    issue(LOAD, 2'b00, 8'hC0);
    issue(SHL, 2'b00, 8'h00);
    chk("shl1_acc", acc_out, 8'h80);
    chk("shl1_carry", carry, 1'b1);
    chk("shl1_ovf", ovf, 1'b0);
    issue(SHL, 2'b00, 8'h00);
    chk("shl2_acc", acc_out, 8'h00);
    chk("shl2_carry", carry, 1'b1);
    chk("shl2_ovf", ovf, 1'b1);
    issue(LOAD, 2'b00, 8'h55);
    chk("ldh_carry", carry, 1'b1);
    chk("ldh_ovf", ovf, 1'b1);
    issue(AND_, 2'b00, 8'h0F);
    chk("and_acc", acc_out, 8'h05);
    issue(OR_, 2'b01, 8'hA0);
    chk("or_acc", acc_out, 8'hA5);
    chk("or_carry", carry, 1'b1);
    issue(LOAD, 2'b10, 8'h77);
    chk("ldk_acc", acc_out, 8'h00);
    chk("ldk_zero", zero, 1'b1);

    // MUL 12*11 with an ignored ADD while busy
    issue(LOAD, 2'b00, 8'd12);
    issue(MUL, 2'b00, 8'd11);
    chk("mul_busy0", busy, 1'b1);
    chk("mul_done0", done, 1'b0);
    mul_wait(1'b1, edges, bcyc);
    chk("mul_edges", edges, 9);
    chk("mul_busycyc", bcyc, 8);
    chk("mul_acc", acc_out, 8'h84);
    chk("mul_done", done, 1'b1);
    chk("mul_busy", busy, 1'b0);
    chk("mul_carry", carry, 1'b0);
    tick();
    chk("mul_after_done", done, 1'b0);
    chk("mul_after_acc", acc_out, 8'h84);

    // MUL 0x20*0x10 -> high half nonzero
    issue(LOAD, 2'b00, 8'h20);
    issue(MUL, 2'b01, 8'h10);
    mul_wait(1'b0, edges, bcyc);
    chk("mul2_edges", edges, 9);
    chk("mul2_acc", acc_out, 8'h00);
    chk("mul2_carry", carry, 1'b1);
    chk("mul2_ovf", ovf, 1'b0);

    // Clear aborts MUL on its 4th busy cycle
    issue(LOAD, 2'b00, 8'h0D);
    issue(MUL, 2'b00, 8'h07);
    tick();
    tick();
    tick();
    chk("abort_busy4", busy, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_acc", acc_out, 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_carry", carry, 1'b0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("abort_nodone", pulses, 0);
    chk("abort_acc_hold", acc_out, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
